// File: rtl/mul_seq_if.sv
// mul_seq_if: operand and result handshake bundle for mul_seq
interface mul_seq_if #(parameter int WIDTH = 58);
  logic [WIDTH-1:0] a, b;
  logic is_signed, in_valid, in_ready;
  logic [2*WIDTH-1:0] out;
  logic out_valid, out_ready, busy;
  modport master(output a, b, is_signed, in_valid, out_ready, input in_ready, out, out_valid, busy);
  modport slave(input a, b, is_signed, in_valid, out_ready, output in_ready, out, out_valid, busy);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: sequential radix-2^STEP signed/unsigned multiplier with valid/ready handshakes
module mul_seq #(
  parameter int WIDTH = 58,
  parameter int STEP = 2
) (
  input logic clk,
  input logic rst_n,
  mul_seq_if.slave bus
);
  localparam int N = (WIDTH + STEP - 1) / STEP;
  localparam int MW = N * STEP;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [MW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, in_hs, last;
  logic [WIDTH-1:0] mag_a, mag_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
    end
  always_comb begin
    in_hs = bus.in_valid && bus.in_ready;
    last = cnt_q == CW'(N - 1);
    state_d = state_q == IDLE ? (in_hs ? BUSY : IDLE)
            : state_q == BUSY ? (last ? DONE : BUSY)
            : in_hs ? BUSY : bus.out_ready ? IDLE : DONE;
  end
  always_comb begin
    bus.in_ready = state_q == IDLE || (state_q == DONE && bus.out_ready);
    bus.busy = state_q == BUSY;
    bus.out_valid = state_q == DONE;
    bus.out = state_q == DONE ? (neg_q ? -acc_q : acc_q) : '0;
  end
  always_comb begin
    mag_a = bus.is_signed && bus.a[WIDTH-1] ? -bus.a : bus.a;
    mag_b = bus.is_signed && bus.b[WIDTH-1] ? -bus.b : bus.b;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    if (in_hs) begin
      mcand_d = (2*WIDTH)'(mag_a);
      mplier_d = MW'(mag_b);
      acc_d = '0;
      cnt_d = '0;
      neg_d = bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end else if (state_q == BUSY) begin
      acc_d = acc_q + mcand_q * (2*WIDTH)'(mplier_q[STEP-1:0]);
      mcand_d = mcand_q << STEP;
      mplier_d = mplier_q >> STEP;
      cnt_d = cnt_q + CW'(1);
    end
  end
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 58: operand width in bits, valid range 2..128.
REQ-002 SHALL provide parameter STEP, default 2: multiplier bits consumed per cycle, valid range 1..8.
REQ-003 SHALL provide parameter-derived constant N = ceil(WIDTH/STEP): number of iteration cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 a  input  WIDTH  multiplicand; sampled on input handshake.
REQ-007 b  input  WIDTH  multiplier; sampled on input handshake.
REQ-008 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on input handshake.
REQ-009 in_valid  input  1  operands present.
REQ-010 in_ready  output  1  block can accept operands.
REQ-011 out  output  2*WIDTH  product.
REQ-012 out_valid  output  1  out holds a completed product.
REQ-013 out_ready  input  1  consumer accepts out.
REQ-014 busy  output  1  iteration in progress.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 Input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-017 Output handshake SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise; it is combinational on out_ready.
REQ-019 On input handshake, the FSM SHALL latch operands, clear the accumulator and iteration counter, and enter BUSY.
REQ-020 When is_signed=1, operands SHALL be converted to magnitudes and the result sign latched as a[WIDTH-1] XOR b[WIDTH-1].
REQ-021 Each BUSY cycle SHALL add (multiplicand × next STEP-bit digit of multiplier, LSB first) shifted into place; the counter SHALL increment.
REQ-022 After the Nth BUSY cycle, the FSM SHALL enter DONE.
REQ-023 out_valid SHALL be 1 exactly in DONE; out SHALL carry the final product, two's-complement negated if the sign is set and is_signed=1.
REQ-024 Latency: if input handshake is at edge T, out_valid SHALL rise after edge T+N.
REQ-025 Output handshake with no simultaneous input handshake SHALL return the FSM to IDLE.
REQ-026 Simultaneous output and input handshake in DONE SHALL go directly to BUSY with the new operands (back-to-back throughput of one result per N+1 cycles).
REQ-027 out and out_valid SHALL hold stable in DONE while out_ready=0 (indefinite backpressure).
REQ-028 in_valid during BUSY SHALL be ignored, with no change to the operation in progress.
REQ-029 The last digit SHALL be zero-extended when WIDTH is not a multiple of STEP.
REQ-030 The product SHALL be exact over the full 2*WIDTH bits, with no truncation or overflow for any operand values, including signed −2^(WIDTH−1) × −2^(WIDTH−1).
REQ-031 busy SHALL be 1 exactly in BUSY.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, out=0, out_valid=0, busy=0, accumulator=0 and counter=0; in_ready SHALL be 1 while in reset.
REQ-033 Reset asserted mid-BUSY or in DONE SHALL discard the operation; no out_valid pulse SHALL follow reset release.
REQ-034 The first input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=58, STEP=2, N=29 unless stated)
REQ-035 a=12, b=12, is_signed=0 -> out=144, out_valid rises after edge T+29.
REQ-036 a=2, b=1, unsigned; then a=0x0AAAAAAAAAAAAAA (alternating 01 pattern), b=0x0CCCCCCCCCCCCCC (0110 pattern), back-to-back with out_ready=1 -> out=2, then the exact 116-bit product versus a golden model; second result N+1 cycles after the first.
REQ-037 Signed: a=−3, b=5 -> out=−15 (116-bit two's complement); a=b=2^57 (most-negative) -> out=2^114; unsigned a=b=2^58−1 -> out=(2^58−1)^2.
REQ-038 Backpressure: hold out_ready=0 for 50 cycles in DONE -> out stable, in_ready=0; pulse in_valid during BUSY -> ignored.
REQ-039 Drop rst_n at BUSY cycle 10 -> outputs zero immediately; after release, no out_valid; a new operation completes correctly.
REQ-040 Parameter sweep WIDTH in {8, 58, 64}, STEP in {1, 3, 4} -> 10k random products match the golden model; latency equals ceil(WIDTH/STEP).
